// File: rtl/deal_sequencer.sv
// deal_sequencer: deals one hand of four card values (1..MAX_VAL) for the
// 24 game from a free-running 4-bit pseudo-random generator. The generator
// is enabled only while dealing and optionally warmed up first. Out-of-range
// draws are rejected. A per-slot retry limit substitutes a fallback value so
// that a stuck generator cannot hang the deal. The finished hand is offered
// through a valid/ack handshake.
module deal_sequencer #(
  parameter int MAX_VAL   = 9,
  parameter int WARMUP    = 3,
  parameter int MAX_TRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        deal,
  input  logic        ack,
  input  logic [3:0]  rand_in,
  output logic        rand_en,
  output logic        busy,
  output logic        cards_valid,
  output logic [15:0] cards,
  output logic [3:0]  fallback
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WARM = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // A deal skips WARM entirely when no warm-up is configured.
  localparam logic [1:0] START_STATE = (WARMUP == 0) ? DRAW : WARM;

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int TW  = $clog2(MAX_TRIES) + 1;

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  localparam logic [TW-1:0]  TRY_LAST  = TW'(MAX_TRIES - 1);
  localparam logic [3:0]     MAX4      = 4'(MAX_VAL);

  logic [1:0]     r_state;
  logic [WCW-1:0] r_warm_cnt;
  logic [1:0]     r_slot;
  logic [TW-1:0]  r_tries;
  logic [15:0]    r_cards;
  logic [3:0]     r_fallback;
  logic           r_valid;

  logic           w_accept;
  logic [3:0]     w_fb_val;
  logic           w_last_slot;

  // Candidate filtering and the fallback value for the current slot.
  always_comb begin
    w_accept    = (rand_in != 4'd0) && (rand_in <= MAX4);
    w_fb_val    = {2'b00, r_slot} + 4'd1;
    w_last_slot = (r_slot == 2'd3);
  end

  // Generator enable and busy decode directly from the state register.
  always_comb begin
    rand_en = (r_state == WARM) || (r_state == DRAW);
    busy    = (r_state == WARM) || (r_state == DRAW);
  end

  // Sequencer state, hand storage and handshake flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_warm_cnt <= '0;
      r_slot     <= 2'd0;
      r_tries    <= '0;
      r_cards    <= 16'h0000;
      r_fallback <= 4'h0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (deal) begin
            r_state    <= START_STATE;
            r_warm_cnt <= '0;
            r_slot     <= 2'd0;
            r_tries    <= '0;
            r_fallback <= 4'h0;
          end
        end
        WARM: begin
          if (r_warm_cnt == WARM_LAST) begin
            r_state <= DRAW;
          end else begin
            r_warm_cnt <= r_warm_cnt + 1'b1;
          end
        end
        DRAW: begin
          if (w_accept) begin
            r_cards[{r_slot, 2'b00} +: 4] <= rand_in;
            r_slot  <= r_slot + 2'd1;
            r_tries <= '0;
            if (w_last_slot) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end
          end else if (r_tries == TRY_LAST) begin
            // Retry budget exhausted: substitute slot+1 so the hand still completes.
            r_cards[{r_slot, 2'b00} +: 4] <= w_fb_val;
            r_fallback[r_slot] <= 1'b1;
            r_slot  <= r_slot + 2'd1;
            r_tries <= '0;
            if (w_last_slot) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end
          end else begin
            r_tries <= r_tries + 1'b1;
          end
        end
        DONE: begin
          // A new deal request takes priority over the acknowledge.
          if (deal) begin
            r_state    <= START_STATE;
            r_valid    <= 1'b0;
            r_warm_cnt <= '0;
            r_slot     <= 2'd0;
            r_tries    <= '0;
            r_fallback <= 4'h0;
          end else if (ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cards       = r_cards;
  assign fallback    = r_fallback;
  assign cards_valid = r_valid;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer. Instance A runs without warm-up and
// instance B uses a three-cycle warm-up. Both use MAX_VAL=9 and MAX_TRIES=8.
module tb_deal_sequencer;

  logic        clk;
  logic        rst;
  logic        deal_a, ack_a, deal_b, ack_b;
  logic [3:0]  rand_a, rand_b;
  logic        en_a, busy_a, valid_a, en_b, busy_b, valid_b;
  logic [15:0] cards_a, cards_b;
  logic [3:0]  fb_a, fb_b;

  int n_checks;
  int n_errors;

  deal_sequencer #(.MAX_VAL(9), .WARMUP(0), .MAX_TRIES(8)) u_dut_a (
    .clk(clk), .rst(rst), .deal(deal_a), .ack(ack_a), .rand_in(rand_a),
    .rand_en(en_a), .busy(busy_a), .cards_valid(valid_a), .cards(cards_a),
    .fallback(fb_a)
  );

  deal_sequencer #(.MAX_VAL(9), .WARMUP(3), .MAX_TRIES(8)) u_dut_b (
    .clk(clk), .rst(rst), .deal(deal_b), .ack(ack_b), .rand_in(rand_b),
    .rand_en(en_b), .busy(busy_b), .cards_valid(valid_b), .cards(cards_b),
    .fallback(fb_b)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vec [7];
  int edges;
  int en_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec[0] = 4'd0;  vec[1] = 4'd12; vec[2] = 4'd3; vec[3] = 4'd9;
    vec[4] = 4'd15; vec[5] = 4'd5;  vec[6] = 4'd7;
    rst = 1'b1;
    deal_a = 1'b0; ack_a = 1'b0; rand_a = 4'd0;
    deal_b = 1'b0; ack_b = 1'b0; rand_b = 4'd0;
    tick();
    tick();
    check("rst_cards", cards_a, 16'h0000);
    check("rst_valid", valid_a, 1'b0);
    check("rst_en", en_b, 1'b0);
    rst = 1'b0;
    tick();

    // Filtered draw with no warm-up.
    deal_a = 1'b1;
    tick();
    deal_a = 1'b0;
    check("filt_busy", busy_a, 1'b1);
    en_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      rand_a = vec[i];
      if (en_a) en_cnt++;
      tick();
      if (i == 5) check("filt_valid_early", valid_a, 1'b0);
    end
    if (en_a) en_cnt++;
    check("filt_valid", valid_a, 1'b1);
    check("filt_cards", cards_a, 16'h7593);
    check("filt_fb", fb_a, 4'h0);
    check("filt_en_cycles", en_cnt, 7);
    check("filt_busy_done", busy_a, 1'b0);

    // Acknowledge returns to IDLE and keeps the hand.
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
    check("ack_valid", valid_a, 1'b0);
    check("ack_cards", cards_a, 16'h7593);

    // Warm-up instance with a constant in-range draw.
    deal_b = 1'b1;
    rand_b = 4'd4;
    tick();
    deal_b = 1'b0;
    edges = 0;
    en_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid_b) break;
      if (en_b) en_cnt++;
      tick();
      edges++;
    end
    check("warm_edges", edges, 7);
    check("warm_en_cycles", en_cnt, 7);
    check("warm_cards", cards_b, 16'h4444);

    // Stuck generator: every slot falls back.
    deal_a = 1'b1;
    rand_a = 4'd15;
    tick();
    deal_a = 1'b0;
    edges = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid_a) break;
      tick();
      edges++;
    end
    check("stuck_edges", edges, 32);
    check("stuck_cards", cards_a, 16'h4321);
    check("stuck_fb", fb_a, 4'hF);

    // Handshake: hold without ack, then deal and ack together.
    rand_a = 4'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_valid", valid_a, 1'b1);
      check("hold_cards", cards_a, 16'h4321);
    end
    deal_a = 1'b1;
    ack_a  = 1'b1;
    tick();
    deal_a = 1'b0;
    ack_a  = 1'b0;
    check("both_valid", valid_a, 1'b0);
    check("both_fb", fb_a, 4'h0);
    check("both_busy", busy_a, 1'b1);
    check("both_cards_kept", cards_a, 16'h4321);

    // Same draw sequence with stray deal and ack pulses during DRAW.
    for (int i = 0; i < 7; i++) begin
      rand_a = vec[i];
      deal_a = (i == 2);
      ack_a  = (i == 4);
      tick();
      if (i == 2) check("ign_partial", cards_a, 16'h4323);
      if (i == 5) check("ign_valid_early", valid_a, 1'b0);
    end
    deal_a = 1'b0;
    ack_a  = 1'b0;
    check("ign_valid", valid_a, 1'b1);
    check("ign_cards", cards_a, 16'h7593);
    check("ign_fb", fb_a, 4'h0);

    // Reset in the middle of DRAW after two cards are stored.
    ack_a = 1'b1;
    tick();
    ack_a  = 1'b0;
    deal_a = 1'b1;
    tick();
    deal_a = 1'b0;
    rand_a = 4'd3;
    tick();
    rand_a = 4'd5;
    tick();
    rand_a = 4'd0;
    check("mid_cards", cards_a, 16'h7553);
    check("mid_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_cards", cards_a, 16'h0000);
    check("arst_fb", fb_a, 4'h0);
    check("arst_valid", valid_a, 1'b0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_en", en_a, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("post_busy", busy_a, 1'b0);
    check("post_valid", valid_a, 1'b0);
    check("post_en", en_a, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Controller that sequences the 4-bit pseudo-random generator to deal one hand of four card values for the 24 game.
- Gates the generator's enable, runs a warm-up period, and filters raw 4-bit draws into the legal card range 1..MAX_VAL.
- Guards against a stuck or badly seeded generator with a per-slot retry limit and a fallback value.
- Presents the finished hand to the game/display logic through a valid/ack handshake.

Parameters:
- MAX_VAL, 9, largest legal card value; legal range is 1..MAX_VAL; must be within 1..15.
- WARMUP, 3, number of clocks the generator is enabled and its output discarded before drawing; 0 means no warm-up.
- MAX_TRIES, 8, number of consecutive rejected draws allowed for one slot before the fallback is used; must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- deal  in  1  request a new hand; level sampled on each edge.
- ack  in  1  consumer has taken the hand.
- rand_in  in  4  current generator output.
- rand_en  out  1  generator enable.
- busy  out  1  high in WARM and DRAW states.
- cards_valid  out  1  hand complete and stable.
- cards  out  16  hand packing: card0 in [3:0], card1 in [7:4], card2 in [11:8], card3 in [15:12].
- fallback  out  4  bit i set means slot i was filled by the fallback value.

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE; cards, fallback, slot index and counters are cleared to 0.
  - rand_en, busy and cards_valid go to 0.
  - Reset asserted mid-deal aborts the deal immediately; no partial hand is ever flagged valid.
- States:
  - IDLE: rand_en=0.
    - deal=1 at an edge: clear fallback, slot index and try count; go to WARM, or directly to DRAW if WARMUP=0.
    - cards retain the previous hand.
  - WARM: rand_en=1; count WARMUP edges, then go to DRAW. Exactly WARMUP clocks are spent in WARM.
  - DRAW: rand_en=1 on every cycle; exactly one candidate is taken per clock.
    - At each edge, rand_in is the candidate.
    - Accept when 1 <= rand_in <= MAX_VAL: write it to cards[slot], increment slot, reset try count.
    - Reject (0 or greater than MAX_VAL): increment try count.
    - If that rejection is the MAX_TRIES-th consecutive one for this slot, write slot+1 to cards[slot] on the same edge, set fallback[slot], increment slot, and reset try count.
    - When slot 3 is filled (accept or fallback), go to DONE; cards_valid rises on that same edge and busy falls.
  - DONE: rand_en=0, cards_valid=1, cards held stable.
    - ack=1: go to IDLE and clear cards_valid; cards retain their values.
    - deal=1: clear cards_valid and start a new deal as from IDLE; deal wins over a simultaneous ack.
- deal asserted in WARM or DRAW is ignored; the current deal continues.
- ack outside DONE is ignored.
- Latency from the deal edge to cards_valid=1 is WARMUP + N edges, where N is the number of DRAW cycles needed (minimum 4, maximum 4*MAX_TRIES).
- Comparisons are unsigned 4-bit; try count width is clog2(MAX_TRIES)+1.
- Duplicate card values are legal.
- Outputs are registered except rand_en and busy, which decode combinationally from state.

Test Plan:
- Reset check: assert rst mid-DRAW after two cards are stored -> cards=0, fallback=0, cards_valid=0, busy=0, rand_en=0 immediately, before the next edge; after release the block stays idle until deal.
- Filtered draw: WARMUP=0, MAX_VAL=9; pulse deal, then drive rand_in 0,12,3,9,15,5,7 on successive edges -> cards=16'h7593, fallback=0, cards_valid high after the 7th edge, rand_en high exactly 7 cycles.
- Warm-up: WARMUP=3 with rand_in fixed at 4 -> rand_en high 7 cycles; cards=16'h4444; cards_valid rises 7 edges after the deal edge.
- Stuck generator: rand_in fixed at 15, MAX_TRIES=8 -> each slot takes the fallback after 8 edges; cards=16'h4321, fallback=4'hF, valid after 32 DRAW edges.
- Handshake: in DONE, hold ack low for 5 cycles -> cards and valid stable; then assert deal and ack in the same cycle -> new deal starts, valid drops, fallback clears.
- Ignored inputs: deal pulsed during DRAW and ack pulsed during DRAW -> no restart, slot sequence unchanged, final hand equals the no-pulse run.
